// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the integer register file: ALU results take priority over a
// small FIFO of long-latency results, and a busy scoreboard drives the issue stall.
module regfile_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int LU_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic [4:0]      issue_rd,
  input  logic            issue_long,
  output logic            issue_stall,
  input  logic            alu_wb_valid,
  input  logic [4:0]      alu_wb_rd,
  input  logic [XLEN-1:0] alu_wb_data,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            reg_write,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] result,
  output logic [31:0]     busy_mask
);

  localparam int PW = (LU_DEPTH > 1) ? $clog2(LU_DEPTH) : 1;
  localparam int CW = $clog2(LU_DEPTH + 1);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } lu_entry_t;

  lu_entry_t         fifo_mem [LU_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [31:0]       busy, busy_next;
  logic              wb_from_lu;

  logic              fifo_full, fifo_empty, push, pop, alu_used;
  logic              pend_rs1, pend_rs2, issue_fire;
  lu_entry_t         head;
  logic              reg_write_next, wb_from_lu_next;
  logic [4:0]        rd_next;
  logic [XLEN-1:0]   result_next;

  assign fifo_full  = (count == CW'(LU_DEPTH));
  assign fifo_empty = (count == '0);
  assign lu_ready   = !fifo_full;
  assign push       = lu_valid && lu_ready;
  assign alu_used   = alu_wb_valid && (alu_wb_rd != 5'd0);
  assign pop        = !alu_used && !fifo_empty;
  assign head       = fifo_mem[rd_ptr];

  // A write still in the output register has not reached the register file yet.
  assign pend_rs1    = reg_write && (rd == issue_rs1) && (issue_rs1 != 5'd0);
  assign pend_rs2    = reg_write && (rd == issue_rs2) && (issue_rs2 != 5'd0);
  assign issue_stall = issue_valid &&
                       (busy[issue_rs1] || busy[issue_rs2] || busy[issue_rd] ||
                        pend_rs1 || pend_rs2);
  assign issue_fire  = issue_valid && !issue_stall;
  assign busy_mask   = busy;

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (reg_write && wb_from_lu) busy_next[rd] = 1'b0;
    if (issue_fire && issue_long && (issue_rd != 5'd0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    reg_write_next  = 1'b0;
    wb_from_lu_next = 1'b0;
    rd_next         = rd;
    result_next     = result;
    if (alu_used) begin
      reg_write_next = 1'b1;
      rd_next        = alu_wb_rd;
      result_next    = alu_wb_data;
    end else if (pop && (head.rd != 5'd0)) begin
      // A popped x0 result is discarded: no write, output fields hold.
      reg_write_next  = 1'b1;
      wb_from_lu_next = 1'b1;
      rd_next         = head.rd;
      result_next     = head.data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      reg_write  <= 1'b0;
      rd         <= '0;
      result     <= '0;
      wb_from_lu <= 1'b0;
    end else begin
      busy       <= busy_next;
      reg_write  <= reg_write_next;
      rd         <= rd_next;
      result     <= result_next;
      wb_from_lu <= wb_from_lu_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; the pointers and count define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{rd: lu_rd, data: lu_data};
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, ALU/LU write-back, scoreboard stalls,
// arbitration conflicts, FIFO back-pressure, x0 handling and mid-operation reset.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_stall;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] result;
  logic [31:0] busy_mask;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.XLEN(32), .LU_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_long(issue_long), .issue_stall(issue_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .reg_write(reg_write), .rd(rd), .result(result), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are stable afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after changing inputs.
  task automatic settle();
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] d, input logic lng);
    issue_valid = v; issue_rs1 = r1; issue_rs2 = r2; issue_rd = d; issue_long = lng;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] d, input logic [31:0] data);
    alu_wb_valid = v; alu_wb_rd = d; alu_wb_data = data;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] d, input logic [31:0] data);
    lu_valid = v; lu_rd = d; lu_data = data;
  endtask

  task automatic check_wb(input string tag, input logic [4:0] exp_rd, input logic [31:0] exp_res);
    check({tag, ".reg_write"}, {31'd0, reg_write}, 32'd1);
    check({tag, ".rd"}, {27'd0, rd}, {27'd0, exp_rd});
    check({tag, ".result"}, result, exp_res);
  endtask

  initial begin
    rst = 1'b1;
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_alu(1'b0, 5'd0, 32'd0);
    set_lu(1'b0, 5'd0, 32'd0);
    tick();
    rst = 1'b0;

    // Reset state
    set_issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b0);
    settle();
    check("rst.busy_mask", busy_mask, 32'd0);
    check("rst.reg_write", {31'd0, reg_write}, 32'd0);
    check("rst.rd", {27'd0, rd}, 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.lu_ready", {31'd0, lu_ready}, 32'd1);
    check("rst.stall", {31'd0, issue_stall}, 32'd0);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();

    // ALU write and pending-write stall
    set_alu(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    check_wb("alu", 5'd5, 32'hDEADBEEF);
    set_issue(1'b1, 5'd5, 5'd0, 5'd6, 1'b0);
    settle();
    check("alu.pend_stall", {31'd0, issue_stall}, 32'd1);
    tick();
    check("alu.idle_wr", {31'd0, reg_write}, 32'd0);
    check("alu.hold_result", result, 32'hDEADBEEF);
    check("alu.stall_drop", {31'd0, issue_stall}, 32'd0);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();

    // Long op: busy set, stall, LU return, clear with simultaneous set of x14
    set_issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
    settle();
    check("long.issue_stall", {31'd0, issue_stall}, 32'd0);
    tick();
    check("long.busy7", busy_mask, 32'h0000_0080);
    set_issue(1'b1, 5'd0, 5'd7, 5'd8, 1'b0);
    set_lu(1'b1, 5'd7, 32'h12345678);
    settle();
    check("long.raw_stall", {31'd0, issue_stall}, 32'd1);
    check("long.lu_ready", {31'd0, lu_ready}, 32'd1);
    tick();
    set_lu(1'b0, 5'd0, 32'd0);
    settle();
    check("long.no_wr_yet", {31'd0, reg_write}, 32'd0);
    check("long.stall_c3", {31'd0, issue_stall}, 32'd1);
    tick();
    check_wb("long.lu_wb", 5'd7, 32'h12345678);
    check("long.busy_still", busy_mask, 32'h0000_0080);
    check("long.stall_c4", {31'd0, issue_stall}, 32'd1);
    set_issue(1'b1, 5'd0, 5'd0, 5'd14, 1'b1);
    settle();
    check("long.fire14", {31'd0, issue_stall}, 32'd0);
    tick();
    check("long.set_clear", busy_mask, 32'h0000_4000);
    set_issue(1'b1, 5'd0, 5'd7, 5'd8, 1'b0);
    settle();
    check("long.stall_gone", {31'd0, issue_stall}, 32'd0);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();

    // Mid-operation reset discards buffered result and busy bits
    set_alu(1'b1, 5'd2, 32'h1);
    set_lu(1'b1, 5'd14, 32'h77);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    set_lu(1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst.busy_mask", busy_mask, 32'd0);
    check("mrst.reg_write", {31'd0, reg_write}, 32'd0);
    check("mrst.rd", {27'd0, rd}, 32'd0);
    check("mrst.result", result, 32'd0);
    check("mrst.lu_ready", {31'd0, lu_ready}, 32'd1);
    tick();
    check("mrst.flushed", {31'd0, reg_write}, 32'd0);
    tick();
    check("mrst.flushed2", {31'd0, reg_write}, 32'd0);

    // Conflict: ALU wins, LU follows one cycle later
    set_alu(1'b1, 5'd3, 32'h33);
    set_lu(1'b1, 5'd9, 32'h99);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    set_lu(1'b0, 5'd0, 32'd0);
    check_wb("conf.alu", 5'd3, 32'h33);
    tick();
    check_wb("conf.lu", 5'd9, 32'h99);
    tick();
    check("conf.idle", {31'd0, reg_write}, 32'd0);

    // Back-pressure: 4 ALU cycles, 3 LU results, order preserved
    set_alu(1'b1, 5'd1, 32'h101);
    set_lu(1'b1, 5'd10, 32'hA10);
    settle();
    check("bp.ready0", {31'd0, lu_ready}, 32'd1);
    tick();
    check_wb("bp.w1", 5'd1, 32'h101);
    set_alu(1'b1, 5'd2, 32'h102);
    set_lu(1'b1, 5'd11, 32'hA11);
    settle();
    check("bp.ready1", {31'd0, lu_ready}, 32'd1);
    tick();
    check_wb("bp.w2", 5'd2, 32'h102);
    set_alu(1'b1, 5'd3, 32'h103);
    set_lu(1'b1, 5'd12, 32'hA12);
    settle();
    check("bp.full2", {31'd0, lu_ready}, 32'd0);
    tick();
    check_wb("bp.w3", 5'd3, 32'h103);
    set_alu(1'b1, 5'd4, 32'h104);
    settle();
    check("bp.full3", {31'd0, lu_ready}, 32'd0);
    tick();
    check_wb("bp.w4", 5'd4, 32'h104);
    set_alu(1'b0, 5'd0, 32'd0);
    settle();
    check("bp.full4", {31'd0, lu_ready}, 32'd0);
    tick();
    check_wb("bp.lu10", 5'd10, 32'hA10);
    check("bp.ready5", {31'd0, lu_ready}, 32'd1);
    tick();
    set_lu(1'b0, 5'd0, 32'd0);
    check_wb("bp.lu11", 5'd11, 32'hA11);
    tick();
    check_wb("bp.lu12", 5'd12, 32'hA12);
    tick();
    check("bp.idle", {31'd0, reg_write}, 32'd0);

    // x0 handling
    set_alu(1'b1, 5'd0, 32'h55);
    set_lu(1'b1, 5'd4, 32'h44);
    tick();
    check("x0.alu_rd0", {31'd0, reg_write}, 32'd0);
    set_alu(1'b1, 5'd0, 32'h66);
    set_lu(1'b0, 5'd0, 32'd0);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    check_wb("x0.lu_x4", 5'd4, 32'h44);
    set_issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    settle();
    check("x0.issue_stall", {31'd0, issue_stall}, 32'd0);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("x0.busy_mask", busy_mask, 32'd0);
    set_lu(1'b1, 5'd0, 32'hBAD);
    tick();
    set_lu(1'b0, 5'd0, 32'd0);
    tick();
    check("x0.lu_rd0_wr", {31'd0, reg_write}, 32'd0);
    check("x0.rd_hold", {27'd0, rd}, 32'd4);
    check("x0.result_hold", result, 32'h44);
    check("x0.ready", {31'd0, lu_ready}, 32'd1);
    tick();
    check("x0.never_wr", {31'd0, reg_write}, 32'd0);
    check("x0.busy_final", busy_mask, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
